pingpong_frame_bram: RTL and testbench
======================================

Name: pingpong_frame_bram

Overview:
- Double-buffered (ping-pong) frame store for the LED cube driver.
- The writer (AXI/CPU side) fills the back bank with byte-enabled writes; the scan driver reads the front bank.
- Banks swap only at a frame boundary, on a request/acknowledge handshake, so a displayed frame never tears.
- Single clock domain; successor to the plain dual-port BRAM, generalised with bank count 2, a read-valid pipeline and swap control.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, per-bank address width; each bank holds 2**ADDR_WIDTH words.
- INIT_FRONT, 0, front bank index after reset (0 or 1).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  writer port enable.
- wr_addr  in  ADDR_WIDTH  writer address (back bank).
- wr_be  in  DATA_WIDTH/8  per-byte write enable.
- wr_din  in  DATA_WIDTH  write data.
- wr_dout  out  DATA_WIDTH  back-bank read-back (read-before-write), 1-cycle latency.
- rd_en  in  1  scan-side read enable.
- rd_addr  in  ADDR_WIDTH  scan-side address (front bank).
- rd_dout  out  DATA_WIDTH  front-bank read data.
- rd_valid  out  1  rd_dout carries data for an accepted rd_en.
- frame_end  in  1  1-cycle pulse from the scan driver at the last read of a frame.
- swap_req  in  1  level; writer holds it high once the back bank is complete.
- swap_done  out  1  1-cycle pulse in the cycle after the banks flip.
- swap_pending  out  1  high while a request waits for frame_end.
- front_bank  out  1  current front bank index.

Behaviour:
- Reset values: wr_dout=0, rd_dout=0, rd_valid=0, swap_done=0, swap_pending=0, front_bank=INIT_FRONT; FSM goes to IDLE. RAM contents are not reset.
- Bank mapping: the writer port always addresses bank ~front_bank; the read port always addresses bank front_bank. The mapping is sampled in the same cycle as the access.
- Writer port:
  - When wr_en=1, each byte k with wr_be[k]=1 is written.
  - wr_dout updates next cycle with the pre-write contents of all bytes at wr_addr.
  - When wr_en=0, wr_dout holds.
- Read port:
  - Latency is 1 cycle (2 with the optional feature). rd_valid is rd_en delayed by that latency.
  - rd_dout holds its last value when no read is in flight.
- FSM IDLE -> PENDING: on swap_req=1 with frame_end=0.
- FSM IDLE with swap_req=1 and frame_end=1 in the same cycle: swap immediately.
- FSM PENDING -> SWAP: on frame_end=1.
  - In PENDING, swap_req deasserted before frame_end means cancel: return to IDLE with no swap.
- FSM SWAP, one cycle:
  - front_bank toggles.
  - swap_done pulses.
  - Next state is WAIT_REL.
- FSM WAIT_REL -> IDLE: when swap_req=0. This prevents a held request from causing repeated swaps.
- frame_end in IDLE without swap_req: ignored.
- swap_pending=1 exactly in PENDING.
- Accesses in the flip cycle:
  - A write in the same cycle frame_end triggers the swap lands in the old back bank, which becomes the new front.
  - A read in that cycle returns old front data.
- Reset mid-frame or mid-swap: the FSM returns to IDLE and front_bank returns to INIT_FRONT. In-flight rd_valid is dropped.
- Addresses wrap naturally within ADDR_WIDTH; there is no range checking.

Optional Feature:
- Macro: PINGPONG_FRAME_BRAM_OUTREG_EN.
- Defined:
  - An extra output register on rd_dout/rd_valid, giving read latency 2 for BRAM output-register inference and timing.
  - The pipeline register resets to 0.
- Undefined: read latency 1, as above. The writer port latency is 1 in both cases.

Decomposition:
- Package pingpong_fb_pkg:
  - swap FSM state enum (IDLE, PENDING, SWAP, WAIT_REL);
  - localparam function for byte-lane count;
  - bank index typedef.
- Sub-module fb_bank_ram: one byte-enabled, read-before-write, true-dual-port bank with no reset. It is instantiated twice, with port muxing in the top level.

Test Plan:
- Reset with INIT_FRONT=0 -> front_bank=0, all outputs 0. Write 0xDEADBEEF to addr 5 with wr_be=4'hF, then read addr 5 -> rd_dout equals bank-0 content, not 0xDEADBEEF, because the write went to bank 1.
- Byte lanes: addr 3 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> wr_dout next cycle=0x11223344; later read-back=0x11BB33DD.
- Handshake:
  - Hold swap_req for 10 cycles, then pulse frame_end -> swap_pending high until the frame_end cycle; front_bank=1 and swap_done=1 the cycle after.
  - Keep swap_req high across two more frame_end pulses -> no further swap.
- Same-cycle case: swap_req rises with frame_end in IDLE -> immediate swap. Cancel case: swap_req drops in PENDING -> IDLE, front_bank unchanged.
- Read latency: rd_en high for 4 cycles at addrs 0..3 -> rd_valid high for 4 cycles starting 1 cycle later (2 with PINGPONG_FRAME_BRAM_OUTREG_EN), data in order.
- Drop rst_n during PENDING with reads in flight -> asynchronous clear: rd_valid=0, swap_pending=0, front_bank=INIT_FRONT in the same cycle.

Source files
------------

// File: rtl/pingpong_fb_pkg.sv
// Shared types for the ping-pong frame store: swap FSM states, bank index type
// and the byte-lane helper.
package pingpong_fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP,
        WAIT_REL
    } swap_state_t;

    typedef logic bank_idx_t;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One frame-store bank: port A is byte-enabled read-before-write, port B is read-only.
// Neither the array nor the read registers are reset, so the bank maps onto block RAM.
module fb_bank_ram
    import pingpong_fb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    input  logic                    b_en,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout
);

    localparam int LANES = lane_count(DATA_WIDTH);

    // NOTE: the storage array gets no reset branch; resetting it would prevent
    // RAM inference and turn every word into discrete flops.
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: non-blocking assignments make a_dout capture the pre-write word,
    // which is the read-before-write behaviour of the port.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
            for (int k = 0; k < LANES; k++) begin
                if (a_be[k]) begin
                    mem[a_addr][k*8 +: 8] <= a_din[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/pingpong_frame_bram.sv
// Double-buffered frame store: writer fills the back bank, scan reads the front bank,
// banks flip only at frame_end. Define PINGPONG_FRAME_BRAM_OUTREG_EN for read latency 2.
module pingpong_frame_bram
    import pingpong_fb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit INIT_FRONT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_din,
    output logic [DATA_WIDTH-1:0]   wr_dout,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_dout,
    output logic                    rd_valid,
    input  logic                    frame_end,
    input  logic                    swap_req,
    output logic                    swap_done,
    output logic                    swap_pending,
    output logic                    front_bank
);

    bank_idx_t             back_bank;
    logic [DATA_WIDTH-1:0] a_dout [2];
    logic [DATA_WIDTH-1:0] b_dout [2];

    assign back_bank = ~front_bank;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fb_bank_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .a_en  (wr_en && (back_bank == bank_idx_t'(b))),
            .a_be  (wr_be),
            .a_addr(wr_addr),
            .a_din (wr_din),
            .a_dout(a_dout[b]),
            .b_en  (rd_en && (front_bank == bank_idx_t'(b))),
            .b_addr(rd_addr),
            .b_dout(b_dout[b])
        );
    end

    // The bank each port used is remembered so outputs hold across a flip.
    bank_idx_t wr_sel;
    bank_idx_t rd_sel;
    logic      wr_seen;
    logic      rd_seen;
    logic      rd_v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel  <= '0;
            wr_seen <= 1'b0;
            rd_sel  <= '0;
            rd_seen <= 1'b0;
            rd_v1   <= 1'b0;
        end else begin
            rd_v1 <= rd_en;
            if (wr_en) begin
                wr_sel  <= back_bank;
                wr_seen <= 1'b1;
            end
            if (rd_en) begin
                rd_sel  <= front_bank;
                rd_seen <= 1'b1;
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_data1;

    assign wr_dout  = wr_seen ? a_dout[wr_sel] : '0;
    assign rd_data1 = rd_seen ? b_dout[rd_sel] : '0;

`ifdef PINGPONG_FRAME_BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] rd_dout_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dout_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_v1;
            if (rd_v1) begin
                rd_dout_q <= rd_data1;
            end
        end
    end

    assign rd_dout  = rd_dout_q;
    assign rd_valid = rd_valid_q;
`else
    assign rd_dout  = rd_data1;
    assign rd_valid = rd_v1;
`endif

    swap_state_t state;
    swap_state_t state_next;
    logic        do_flip;

    assign do_flip      = (state_next == SWAP);
    assign swap_pending = (state == PENDING);

    // The flip lands on the edge entering SWAP, so a same-cycle write/read still
    // sees the old mapping and SWAP itself is the cycle after the flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            front_bank <= INIT_FRONT;
            swap_done  <= 1'b0;
        end else begin
            state     <= state_next;
            swap_done <= do_flip;
            if (do_flip) begin
                front_bank <= ~front_bank;
            end
        end
    end

    // NOTE: state_next is assigned a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (swap_req) begin
                    state_next = frame_end ? SWAP : PENDING;
                end
            end
            PENDING: begin
                if (!swap_req) begin
                    state_next = IDLE;
                end else if (frame_end) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!swap_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pingpong_frame_bram.sv
// Scoreboard bench for pingpong_frame_bram: stimulus pushes expected words,
// a negedge monitor pops them whenever the DUT presents read or write-back data.
module tb_pingpong_frame_bram;

`ifdef PINGPONG_FRAME_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    typedef struct {
        bit          care;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_din = '0;
    logic [31:0] wr_dout;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_dout;
    logic        rd_valid;
    logic        frame_end = 1'b0;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic        swap_pending;
    logic        front_bank;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic wr_issued;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    pingpong_frame_bram #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .INIT_FRONT(1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_be       (wr_be),
        .wr_din      (wr_din),
        .wr_dout     (wr_dout),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_dout     (rd_dout),
        .rd_valid    (rd_valid),
        .frame_end   (frame_end),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .swap_pending(swap_pending),
        .front_bank  (front_bank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_issued <= 1'b0;
        else        wr_issued <= wr_en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data.
    always @(negedge clk) begin : monitor
        rd_exp_t re;
        wr_exp_t we;
        if (rst_n && rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %h, expected no read", rd_dout);
            end else begin
                re = rd_q.pop_front();
                check("rd_data", rd_dout, re.data);
                check("rd_latency", 32'(cyc - re.cyc), 32'(LAT));
            end
        end
        if (wr_issued) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: write-back with no issued write");
            end else begin
                we = wr_q.pop_front();
                if (we.care) check("wr_dout", wr_dout, we.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d,
                      input bit care, input logic [31:0] old);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_din  = d;
        wr_q.push_back('{care, old});
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_q.push_back('{exp, cyc});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && rd_q.size() != 0; i++) tick();
        tick();
        check("rd_drain", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] lat_exp [4];
        lat_exp = '{32'hB100_0000, 32'hB100_0001, 32'hB100_0002, 32'h11BB_33DD};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_dout", wr_dout, 32'd0);
        check("rst_rd_dout", rd_dout, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_front_bank", 32'(front_bank), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill bank 1 (back) and exercise byte lanes
        wr(8'd0, 4'hF, 32'hB100_0000, 1'b0, 32'd0);
        wr(8'd1, 4'hF, 32'hB100_0001, 1'b0, 32'd0);
        wr(8'd2, 4'hF, 32'hB100_0002, 1'b0, 32'd0);
        wr(8'd3, 4'hF, 32'h1122_3344, 1'b0, 32'd0);
        wr(8'd5, 4'hF, 32'h0101_0101, 1'b0, 32'd0);
        wr(8'd3, 4'b0101, 32'hAABB_CCDD, 1'b1, 32'h1122_3344);
        wr(8'd3, 4'b0000, 32'hFFFF_FFFF, 1'b1, 32'h11BB_33DD);

        // Held request, then frame_end with a flip-cycle write to addr 7
        swap_req = 1'b1;
        check("idle_pending", 32'(swap_pending), 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("pending_hold", 32'(swap_pending), 32'd1);
            check("pending_front", 32'(front_bank), 32'd0);
            tick();
        end
        frame_end = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd7; wr_be = 4'hF; wr_din = 32'h7777_7777;
        wr_q.push_back('{1'b0, 32'd0});
        check("pending_at_fe", 32'(swap_pending), 32'd1);
        tick();
        frame_end = 1'b0;
        wr_en = 1'b0;
        check("swap1_front", 32'(front_bank), 32'd1);
        check("swap1_done", 32'(swap_done), 32'd1);
        check("swap1_pending", 32'(swap_pending), 32'd0);
        tick();
        check("swap1_done_pulse", 32'(swap_done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
            check("held_no_swap_front", 32'(front_bank), 32'd1);
            check("held_no_swap_done", 32'(swap_done), 32'd0);
        end
        tick();
        check("held_no_swap_late", 32'(swap_done), 32'd0);
        swap_req = 1'b0;
        tick();

        // Front is bank 1: latency run over addrs 0..3, flip-cycle write at 7
        for (int i = 0; i < 4; i++) rd(8'(i), lat_exp[i]);
        rd(8'd7, 32'h7777_7777);
        drain();
        repeat (3) tick();
        check("rd_dout_hold", rd_dout, 32'h7777_7777);

        // Fill bank 0 (back); frame_end alone is ignored
        wr(8'd5, 4'hF, 32'h0B0B_0B05, 1'b0, 32'd0);
        wr(8'd0, 4'hF, 32'hB000_0000, 1'b0, 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("fe_ignored_front", 32'(front_bank), 32'd1);
        check("fe_ignored_pending", 32'(swap_pending), 32'd0);

        // Same-cycle request + frame_end; read in flip cycle sees old front
        swap_req = 1'b1; frame_end = 1'b1;
        rd_en = 1'b1; rd_addr = 8'd5;
        rd_q.push_back('{32'h0101_0101, cyc});
        tick();
        swap_req = 1'b0; frame_end = 1'b0; rd_en = 1'b0;
        check("imm_swap_front", 32'(front_bank), 32'd0);
        check("imm_swap_done", 32'(swap_done), 32'd1);
        tick();
        check("imm_swap_done_pulse", 32'(swap_done), 32'd0);
        tick();

        // Front bank 0: write to back goes to bank 1, read returns bank 0
        wr(8'd5, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0101_0101);
        rd(8'd5, 32'h0B0B_0B05);
        rd(8'd0, 32'hB000_0000);
        drain();

        // Cancel: request dropped while pending
        swap_req = 1'b1;
        tick();
        check("cancel_pending", 32'(swap_pending), 32'd1);
        tick();
        swap_req = 1'b0;
        tick();
        check("cancel_idle", 32'(swap_pending), 32'd0);
        check("cancel_front", 32'(front_bank), 32'd0);
        check("cancel_done", 32'(swap_done), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("cancel_fe_front", 32'(front_bank), 32'd0);

        // Move front to bank 1, then reset during PENDING with a read in flight
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        swap_req = 1'b0; frame_end = 1'b0;
        check("pre_rst_front", 32'(front_bank), 32'd1);
        tick();
        tick();
        swap_req = 1'b1;
        tick();
        check("pre_rst_pending", 32'(swap_pending), 32'd1);
        rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd_valid", 32'(rd_valid), 32'd0);
        check("async_pending", 32'(swap_pending), 32'd0);
        check("async_front", 32'(front_bank), 32'd0);
        check("async_rd_dout", rd_dout, 32'd0);
        swap_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("post_rst_front", 32'(front_bank), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
